// File: rtl/mmio_pkg.sv
// Shared register map and constants for the memory-mapped I/O peripheral.
package mmio_pkg;

   localparam logic [2:0] REG_ID    = 3'd0;
   localparam logic [2:0] REG_LEDS  = 3'd1;
   localparam logic [2:0] REG_HEX   = 3'd2;
   localparam logic [2:0] REG_SW    = 3'd3;
   localparam logic [2:0] REG_KEY   = 3'd4;
   localparam logic [2:0] REG_KEDGE = 3'd5;
   localparam logic [2:0] REG_TIMER = 3'd6;
   localparam logic [2:0] REG_TCMP  = 3'd7;

   localparam logic [31:0] ID_VALUE  = 32'h4D4D_0001;
   localparam int          MATCH_BIT = 31;

endpackage

// File: rtl/io_sync_edge.sv
// Multi-flop synchroniser for asynchronous inputs with a one-cycle rising-edge pulse
// derived from the synchronised level.
module io_sync_edge #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] level,
   output logic [W-1:0] rise
);

   logic [STAGES-1:0][W-1:0] chain;
   logic [W-1:0]             level_q;

   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain   <= '0;
         level_q <= '0;
      end else begin
         chain   <= {chain[STAGES-2:0], d};
         level_q <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~level_q;

endmodule

// File: rtl/mmio_periph.sv
// I/O window of the SoC data bus: LED/HEX registers, synchronised switches and keys,
// sticky key-press capture and a prescaled timer with compare flag.
module mmio_periph
   import mmio_pkg::*;
#(
   parameter int IO_BIT      = 8,
   parameter int NUM_LEDS    = 10,
   parameter int NUM_HEX     = 6,
   parameter int NUM_SW      = 10,
   parameter int NUM_KEYS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE    = 50
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            addr,
   input  logic [31:0]            writedata,
   input  logic                   memwrite,
   output logic                   is_io,
   output logic [31:0]            io_rdata,
   input  logic [NUM_SW-1:0]      sw,
   input  logic [NUM_KEYS-1:0]    key_n,
   output logic [NUM_LEDS-1:0]    leds,
   output logic [4*NUM_HEX-1:0]   hex_digits
);

   // Bit 31 of KEY_EDGE carries the timer match flag, so keys must stay below it.
   if (NUM_KEYS < 1 || NUM_KEYS > 31) begin : g_bad_num_keys
      $error("mmio_periph: NUM_KEYS must be in 1..31");
   end

   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   logic [2:0]          idx;
   logic                we;
   logic [NUM_SW-1:0]   sw_level;
   logic [NUM_SW-1:0]   unused_sw_rise;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_rise;
   logic [NUM_KEYS-1:0] key_edge;
   logic                match_flag;
   logic [PW-1:0]       presc;
   logic [31:0]         timer;
   logic [31:0]         timer_cmp;
   logic [31:0]         timer_inc;
   logic                tick;
   logic                timer_we;
   logic                kedge_w1c;
   logic                match_set;
   logic                unused_bits;

   assign is_io     = addr[IO_BIT];
   assign idx       = addr[4:2];
   assign we        = memwrite & is_io;
   assign tick      = (presc == PS_LAST);
   assign timer_we  = we && (idx == REG_TIMER);
   assign kedge_w1c = we && (idx == REG_KEDGE);
   assign timer_inc = timer + 32'd1;
   // Only a tick can raise the match; a store that lands on the compare value does not.
   assign match_set = tick && !timer_we && (timer_inc == timer_cmp);
   assign unused_bits = ^{addr, unused_sw_rise};

   io_sync_edge #(.W(NUM_SW), .STAGES(SYNC_STAGES)) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw),
      .level (sw_level),
      .rise  (unused_sw_rise)
   );

   io_sync_edge #(.W(NUM_KEYS), .STAGES(SYNC_STAGES)) u_key_sync (
      .clk   (clk),
      .reset (reset),
      .d     (~key_n),
      .level (key_level),
      .rise  (key_rise)
   );

   // NOTE: every register here, including the compare value, gets a reset value;
   // a mid-run reset must override any store, tick or edge arriving on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         leds       <= '0;
         hex_digits <= '0;
         key_edge   <= '0;
         match_flag <= 1'b0;
         presc      <= '0;
         timer      <= '0;
         timer_cmp  <= 32'hFFFF_FFFF;
      end else begin
         if (we && idx == REG_LEDS) leds       <= writedata[NUM_LEDS-1:0];
         if (we && idx == REG_HEX)  hex_digits <= writedata[4*NUM_HEX-1:0];
         if (we && idx == REG_TCMP) timer_cmp  <= writedata;

         presc <= tick ? '0 : presc + 1'b1;

         if (timer_we)  timer <= writedata;
         else if (tick) timer <= timer_inc;

         // New presses are OR-ed in after the clear so a coincident set wins.
         key_edge   <= (key_edge & ~(kedge_w1c ? writedata[NUM_KEYS-1:0] : '0)) | key_rise;
         match_flag <= (match_flag & ~(kedge_w1c & writedata[MATCH_BIT])) | match_set;
      end
   end

   // NOTE: the read mux assigns a default before the case so no path leaves io_rdata
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      io_rdata = '0;
      case (idx)
         REG_ID:    io_rdata = ID_VALUE;
         REG_LEDS:  io_rdata = 32'(leds);
         REG_HEX:   io_rdata = 32'(hex_digits);
         REG_SW:    io_rdata = 32'(sw_level);
         REG_KEY:   io_rdata = 32'(key_level);
         REG_KEDGE: io_rdata = 32'(key_edge) | (32'(match_flag) << MATCH_BIT);
         REG_TIMER: io_rdata = timer;
         REG_TCMP:  io_rdata = timer_cmp;
         default:   io_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph: a cycle-level behavioural model checked every
// negative edge, plus directed reads with hand-computed expectations.
module tb_mmio_periph;

   localparam int NUM_LEDS = 10;
   localparam int NUM_HEX  = 6;
   localparam int NUM_SW   = 10;
   localparam int NUM_KEYS = 4;
   localparam int STAGES   = 2;
   localparam int PRESCALE = 4;

   logic                  clk;
   logic                  reset;
   logic [31:0]           addr;
   logic [31:0]           writedata;
   logic                  memwrite;
   logic                  is_io;
   logic [31:0]           io_rdata;
   logic [NUM_SW-1:0]     sw;
   logic [NUM_KEYS-1:0]   key_n;
   logic [NUM_LEDS-1:0]   leds;
   logic [4*NUM_HEX-1:0]  hex_digits;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   mmio_periph #(
      .IO_BIT(8), .NUM_LEDS(NUM_LEDS), .NUM_HEX(NUM_HEX), .NUM_SW(NUM_SW),
      .NUM_KEYS(NUM_KEYS), .SYNC_STAGES(STAGES), .PRESCALE(PRESCALE)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .memwrite(memwrite),
      .is_io(is_io), .io_rdata(io_rdata), .sw(sw), .key_n(key_n),
      .leds(leds), .hex_digits(hex_digits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: register values by name, input history by edge, timer from elapsed cycles.
   logic [NUM_LEDS-1:0]  m_leds;
   logic [4*NUM_HEX-1:0] m_hex;
   logic [31:0]          m_kedge;
   logic [31:0]          m_timer;
   logic [31:0]          m_cmp;
   int                   m_cycles;
   logic [NUM_KEYS-1:0]  m_key_hist [0:STAGES];
   logic [NUM_SW-1:0]    m_sw_hist  [0:STAGES-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [2:0]          idx;
      logic                we;
      logic                tick;
      logic                match;
      logic [NUM_KEYS-1:0] pressed;
      logic [31:0]         set_bits;
      if (reset) begin
         m_leds   = '0;
         m_hex    = '0;
         m_kedge  = '0;
         m_timer  = '0;
         m_cmp    = 32'hFFFF_FFFF;
         m_cycles = 0;
         for (int i = 0; i <= STAGES; i++) m_key_hist[i] = '0;
         for (int i = 0; i < STAGES; i++)  m_sw_hist[i]  = '0;
      end else begin
         idx     = addr[4:2];
         we      = memwrite && addr[8];
         tick    = (m_cycles % PRESCALE) == (PRESCALE - 1);
         pressed = m_key_hist[STAGES-1] & ~m_key_hist[STAGES];
         match   = 1'b0;
         if (we && idx == 3'd6) m_timer = writedata;
         else if (tick) begin
            m_timer = m_timer + 32'd1;
            match   = (m_timer == m_cmp);
         end
         set_bits = 32'(pressed);
         if (match) set_bits[31] = 1'b1;
         m_kedge = (m_kedge & ~((we && idx == 3'd5) ? writedata : 32'd0)) | set_bits;
         if (we && idx == 3'd1) m_leds = writedata[NUM_LEDS-1:0];
         if (we && idx == 3'd2) m_hex  = writedata[4*NUM_HEX-1:0];
         if (we && idx == 3'd7) m_cmp  = writedata;
         for (int i = STAGES; i > 0; i--) m_key_hist[i] = m_key_hist[i-1];
         m_key_hist[0] = ~key_n;
         for (int i = STAGES - 1; i > 0; i--) m_sw_hist[i] = m_sw_hist[i-1];
         m_sw_hist[0] = sw;
         m_cycles++;
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      case (a[4:2])
         3'd0:    return 32'h4D4D_0001;
         3'd1:    return 32'(m_leds);
         3'd2:    return 32'(m_hex);
         3'd3:    return 32'(m_sw_hist[STAGES-1]);
         3'd4:    return 32'(m_key_hist[STAGES-1]);
         3'd5:    return m_kedge;
         3'd6:    return m_timer;
         default: return m_cmp;
      endcase
   endfunction

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_leds",  32'(leds), 32'(m_leds));
         check("cyc_hex",   32'(hex_digits), 32'(m_hex));
         check("cyc_is_io", 32'(is_io), 32'(addr[8]));
         check("cyc_rdata", io_rdata, model_rd(addr));
      end
   end

   // Inputs change 2 time units after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      addr      = a;
      writedata = d;
      memwrite  = 1'b1;
      step();
      memwrite  = 1'b0;
   endtask

   task automatic rd_now(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr     = a;
      memwrite = 1'b0;
      #1;
      check(name, io_rdata, exp);
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      addr      = '0;
      writedata = '0;
      memwrite  = 1'b0;
      sw        = 10'h2A5;
      key_n     = '1;
      repeat (2) @(posedge clk);
      #2;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_hex",  32'(hex_digits), 32'd0);
      rd_now("rst_timer", 32'h118, 32'd0);           step();
      rd_now("rst_cmp",   32'h11C, 32'hFFFF_FFFF);   step();
      rd_now("rst_id",    32'h100, 32'h4D4D_0001);   step();
      rd_now("sw_level",  32'h10C, 32'h2A5);

      // Output registers, readback, ignored stores
      store(32'h104, 32'h3FF);
      check("leds_wr", 32'(leds), 32'h3FF);
      store(32'h108, 32'h0012_3456);
      check("hex_wr", 32'(hex_digits), 32'h0012_3456);
      rd_now("leds_rb", 32'h104, 32'h3FF);          step();
      rd_now("hex_rb",  32'h108, 32'h0012_3456);
      store(32'h004, 32'h0);
      store(32'h008, 32'h0);
      store(32'h100, 32'h0);
      store(32'h10C, 32'hFFFF_FFFF);
      check("ram_wr_leds", 32'(leds), 32'h3FF);
      check("ram_wr_hex",  32'(hex_digits), 32'h0012_3456);
      rd_now("ro_id", 32'h100, 32'h4D4D_0001);
      rd_now("ro_sw", 32'h10C, 32'h2A5);
      store(32'h104, 32'hFFFF_FC55);
      rd_now("leds_lsbs", 32'h104, 32'h055);

      // Key synchronisation and sticky press capture
      key_n = 4'b1011;
      step();
      rd_now("key_lvl_1cyc", 32'h110, 32'h0);        step();
      rd_now("key_lvl_2cyc", 32'h110, 32'h4);
      rd_now("kedge_early",  32'h114, 32'h0);        step();
      rd_now("kedge_set",    32'h114, 32'h4);
      key_n = 4'b1010;
      step(); step();
      store(32'h114, 32'h4);
      rd_now("w1c_other_set", 32'h114, 32'h1);
      key_n = 4'b1111;
      step(); step(); step();
      store(32'h114, 32'h1);
      rd_now("kedge_clear", 32'h114, 32'h0);
      key_n = 4'b1110;
      step(); step();
      store(32'h114, 32'h1);
      rd_now("set_wins", 32'h114, 32'h1);
      key_n = 4'b1111;

      // Timer: prescale, wrap, write priority
      reset_pulse();
      repeat (12) step();
      rd_now("timer_12cyc", 32'h118, 32'd3);
      store(32'h118, 32'hFFFF_FFFF);
      rd_now("timer_wr", 32'h118, 32'hFFFF_FFFF);
      step(); step(); step();
      rd_now("timer_wrap", 32'h118, 32'd0);
      rd_now("wrap_no_flag", 32'h114, 32'd0);
      step(); step(); step();
      store(32'h118, 32'h100);
      rd_now("wr_beats_tick", 32'h118, 32'h100);
      repeat (4) step();
      rd_now("presc_kept", 32'h118, 32'h101);

      // Compare match flag
      reset_pulse();
      store(32'h11C, 32'd5);
      repeat (18) step();
      rd_now("pre_match_flag",  32'h114, 32'd0);
      rd_now("pre_match_timer", 32'h118, 32'd4);
      step();
      rd_now("match_flag",  32'h114, 32'h8000_0000);
      rd_now("match_timer", 32'h118, 32'd5);
      store(32'h114, 32'h8000_0000);
      rd_now("match_w1c", 32'h114, 32'd0);
      store(32'h118, 32'd5);
      rd_now("wr_eq_no_flag", 32'h114, 32'd0);
      rd_now("wr_eq_timer",   32'h118, 32'd5);

      // Mid-run reset with a press edge and a store pending
      key_n = 4'b1101;
      step(); step();
      reset     = 1'b1;
      addr      = 32'h104;
      writedata = 32'h2AA;
      memwrite  = 1'b1;
      step();
      reset    = 1'b0;
      memwrite = 1'b0;
      check("midrst_leds", 32'(leds), 32'd0);
      rd_now("midrst_kedge", 32'h114, 32'd0);
      rd_now("midrst_timer", 32'h118, 32'd0);
      rd_now("midrst_cmp",   32'h11C, 32'hFFFF_FFFF);
      step();
      rd_now("midrst_no_residue", 32'h114, 32'd0);
      step(); step();
      rd_now("held_key_redetect", 32'h114, 32'h2);
      key_n = 4'b1111;
      repeat (3) step();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
